// File: rtl/sm_step_ctrl.sv
// sm_step_ctrl: CPU clock-enable sequencer (run / single-step / burst); address breakpoint halt when SM_STEP_BREAKPOINT_EN is defined
module sm_step_ctrl #(
  parameter int SHIFT = 16
) (
  input  logic        clkIn,
  input  logic        rst,
  input  logic        runReq,
  input  logic        stepReq,
  input  logic        burstReq,
  input  logic [7:0]  burstLen,
  input  logic [3:0]  divide,
  input  logic [31:0] pcAddr,
  input  logic [31:0] breakAddr,
  input  logic        breakEn,
  output logic        cpuClkEn,
  output logic        halted,
  output logic        bpHit,
  output logic [1:0]  state,
  output logic [31:0] cycleCnt
);
  typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, STEP = 2'd2, BURST = 2'd3} state_t;
  state_t st, nxt;
  logic step_q, burst_q, run_armed, first_tick, bp_cond;
  logic go_run, go_burst, go_step, leave, tick, pulse, bp_halt;
  logic [3:0] div_l;
  logic [7:0] remaining;
  logic [31:0] pre, lim;
  assign state = st;
`ifdef SM_STEP_BREAKPOINT_EN
  assign bp_cond = breakEn && pcAddr == breakAddr && !first_tick;
`else
  logic unused_ok;
  assign unused_ok = ^{pcAddr, breakAddr, breakEn, first_tick};
  assign bp_cond = 1'b0;
`endif
  always_comb begin
    lim = (32'd1 << (SHIFT + 32'(div_l))) - 32'd1;
    tick = pre == lim;
    go_run = runReq && run_armed;
    go_burst = burstReq && !burst_q && burstLen != 8'd0;
    go_step = stepReq && !step_q;
    leave = st == HALT && (go_run || go_burst || go_step);
    bp_halt = tick && bp_cond && ((st == RUN && runReq) || st == BURST);
    // STEP holds off a second pulse while the first one is still on the output
    pulse = tick && !bp_halt && ((st == RUN && runReq) || st == BURST || (st == STEP && !cpuClkEn));
    nxt = st;
    case (st)
      HALT:    nxt = go_run ? RUN : go_burst ? BURST : go_step ? STEP : HALT;
      RUN:     nxt = (!runReq || bp_halt) ? HALT : RUN;
      STEP:    nxt = cpuClkEn ? HALT : STEP;
      default: nxt = (bp_halt || (pulse && remaining == 8'd1)) ? HALT : BURST;
    endcase
  end
  always_ff @(posedge clkIn) begin
    if (rst) begin
      st <= HALT;
      halted <= 1'b1;
      cpuClkEn <= 1'b0;
      bpHit <= 1'b0;
      cycleCnt <= 32'd0;
      remaining <= 8'd0;
      pre <= 32'd0;
      step_q <= 1'b0;
      burst_q <= 1'b0;
      run_armed <= 1'b1;
      first_tick <= 1'b0;
      div_l <= 4'd0;
    end else begin
      st <= nxt;
      halted <= nxt == HALT;
      cpuClkEn <= pulse;
      cycleCnt <= cycleCnt + {31'd0, cpuClkEn};
      pre <= (st == HALT || tick) ? 32'd0 : pre + 32'd1;
      step_q <= stepReq;
      burst_q <= burstReq;
      run_armed <= !runReq || (run_armed && !bp_halt);
      bpHit <= bp_halt || (bpHit && !leave);
      first_tick <= leave || (first_tick && !(st != HALT && tick));
      if (leave)
        div_l <= divide;
      if (leave && !go_run && go_burst)
        remaining <= burstLen;
      else if (pulse && st == BURST)
        remaining <= remaining - 8'd1;
    end
  end
endmodule

// File: tb/tb_sm_step_ctrl.sv
// tb_sm_step_ctrl: table vectors, directed multi-cycle sequences and a randomized run checked against a cycle model
module tb_sm_step_ctrl;
  localparam int SHIFT = 0;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, runReq, stepReq, burstReq, breakEn;
  logic [7:0] burstLen;
  logic [3:0] divide;
  logic [31:0] pcAddr, breakAddr;
  logic cpuClkEn, halted, bpHit;
  logic [1:0] state;
  logic [31:0] cycleCnt;
  int checks = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  sm_step_ctrl #(.SHIFT(SHIFT)) dut (
    .clkIn(clk), .rst(rst), .runReq(runReq), .stepReq(stepReq), .burstReq(burstReq),
    .burstLen(burstLen), .divide(divide), .pcAddr(pcAddr), .breakAddr(breakAddr),
    .breakEn(breakEn), .cpuClkEn(cpuClkEn), .halted(halted), .bpHit(bpHit),
    .state(state), .cycleCnt(cycleCnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: countdown to the next tick rather than a prescaler compare
  logic s_rst, s_run, s_step, s_burst, s_ben;
  logic [7:0] s_len;
  logic [3:0] s_div;
  logic [31:0] s_pc, s_ba;
  always @(posedge clk) begin
    s_rst <= rst; s_run <= runReq; s_step <= stepReq; s_burst <= burstReq; s_ben <= breakEn;
    s_len <= burstLen; s_div <= divide; s_pc <= pcAddr; s_ba <= breakAddr;
  end

  logic [1:0] m_st;
  int m_wait, m_L, m_rem;
  bit m_en, m_first, m_bp, m_armed, m_ps, m_pb;
  logic [31:0] m_cnt;

  task automatic model_step();
    bit se, be, pe, bpc;
    if (s_rst) begin
      m_st = 0; m_en = 0; m_bp = 0; m_cnt = 0; m_rem = 0; m_ps = 0; m_pb = 0;
      m_armed = 1; m_wait = 0; m_first = 0; m_L = 0;
      return;
    end
    m_cnt = m_cnt + {31'd0, m_en};
    pe = m_en;
    m_en = 0;
    se = s_step && !m_ps;
    be = s_burst && !m_pb;
`ifdef SM_STEP_BREAKPOINT_EN
    bpc = s_ben && s_pc == s_ba && !m_first;
`else
    bpc = 0;
`endif
    case (m_st)
      2'd0: begin
        if ((s_run && m_armed) || (be && s_len != 0) || se) begin
          m_st = (s_run && m_armed) ? 2'd1 : (be && s_len != 0) ? 2'd3 : 2'd2;
          if (m_st == 2'd3) m_rem = int'(s_len);
          m_L = (1 << (SHIFT + int'(s_div))) - 1;
          m_wait = m_L;
          m_first = 1;
          m_bp = 0;
        end
      end
      2'd1: begin
        if (!s_run) m_st = 0;
        else if (m_wait > 0) m_wait--;
        else if (bpc) begin m_st = 0; m_bp = 1; m_armed = 0; end
        else begin m_en = 1; m_first = 0; m_wait = m_L; end
      end
      2'd2: begin
        if (pe) m_st = 0;
        else if (m_wait > 0) m_wait--;
        else begin m_en = 1; m_first = 0; end
      end
      default: begin
        if (m_wait > 0) m_wait--;
        else if (bpc) begin m_st = 0; m_bp = 1; m_armed = 0; end
        else begin
          m_en = 1; m_first = 0; m_wait = m_L; m_rem--;
          if (m_rem == 0) m_st = 0;
        end
      end
    endcase
    if (!s_run) m_armed = 1;
    m_ps = s_step;
    m_pb = s_burst;
  endtask

  always @(negedge clk) begin
    model_step();
    if (chk_en)
      chk("model", {cpuClkEn, state, halted, bpHit, cycleCnt},
          {m_en, m_st, m_st == 2'd0, m_bp, m_cnt});
  end

  typedef struct {
    logic rst, run, step, burst;
    logic [7:0] len;
    logic en;
    logic [1:0] st;
    logic hl;
    logic [31:0] cnt;
  } vec_t;

  function automatic vec_t mk(input int r, ru, s, b, l, e, st, h, c);
    mk.rst = r[0]; mk.run = ru[0]; mk.step = s[0]; mk.burst = b[0]; mk.len = l[7:0];
    mk.en = e[0]; mk.st = st[1:0]; mk.hl = h[0]; mk.cnt = c;
  endfunction

  initial begin
    vec_t tbl[19];
    int n, first, last, prev, bad;
    logic [31:0] c0;
    //             rst run stp brs len  en st hl cnt
    tbl[0]  = mk(1, 0, 0, 0, 0,  0, 0, 1, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0,  0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0,  0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 1, 0, 0,  0, 2, 0, 0);
    tbl[4]  = mk(0, 0, 1, 0, 0,  1, 2, 0, 0);
    tbl[5]  = mk(0, 0, 1, 0, 0,  0, 0, 1, 1);
    tbl[6]  = mk(0, 0, 1, 0, 0,  0, 0, 1, 1);
    tbl[7]  = mk(0, 0, 1, 0, 0,  0, 0, 1, 1);
    tbl[8]  = mk(0, 0, 1, 0, 0,  0, 0, 1, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0,  0, 0, 1, 1);
    tbl[10] = mk(0, 0, 0, 1, 2,  0, 3, 0, 1);
    tbl[11] = mk(0, 0, 0, 1, 2,  1, 3, 0, 1);
    tbl[12] = mk(0, 0, 0, 1, 2,  1, 0, 1, 2);
    tbl[13] = mk(0, 0, 0, 1, 2,  0, 0, 1, 3);
    tbl[14] = mk(0, 0, 0, 0, 0,  0, 0, 1, 3);
    tbl[15] = mk(0, 0, 0, 1, 0,  0, 0, 1, 3);
    tbl[16] = mk(0, 1, 0, 0, 0,  0, 1, 0, 3);
    tbl[17] = mk(0, 1, 0, 0, 0,  1, 1, 0, 3);
    tbl[18] = mk(0, 0, 0, 0, 0,  0, 0, 1, 4);

    rst = 1; runReq = 0; stepReq = 0; burstReq = 0; burstLen = 0; divide = 0;
    pcAddr = 0; breakAddr = 32'h10; breakEn = 0;
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    rst = 0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!halted || state != 2'd0 || cpuClkEn || cycleCnt != 0) bad++;
    end
    chk("reset_idle", bad, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; runReq = tbl[i].run; stepReq = tbl[i].step;
      burstReq = tbl[i].burst; burstLen = tbl[i].len;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {cpuClkEn, state, halted, cycleCnt},
          {tbl[i].en, tbl[i].st, tbl[i].hl, tbl[i].cnt});
    end

    // burst of 5 on consecutive cycles
    c0 = cycleCnt;
    burstLen = 5; burstReq = 1;
    n = 0; first = 0; last = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (cpuClkEn) begin n++; if (first == 0) first = k; last = k; end
      if (k == 1) burstReq = 0;
    end
    chk("burst5_count", n, 5);
    chk("burst5_first", first, 2);
    chk("burst5_last", last, 6);
    chk("burst5_cnt", cycleCnt, c0 + 5);
    chk("burst5_halted", halted, 1);

    // divided run, L = 7: pulses 8 apart, runReq dropped on a cycle whose tick is due
    divide = 3; runReq = 1;
    n = 0; first = 0; last = 0; prev = 0; bad = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (cpuClkEn) begin
        n++;
        if (first == 0) first = k;
        if (prev != 0 && k - prev != 8) bad++;
        prev = k; last = k;
      end
      if (k == 40) runReq = 0;
    end
    chk("div_count", n, 4);
    chk("div_first", first, 9);
    chk("div_last", last, 33);
    chk("div_spacing", bad, 0);
    chk("div_halted", halted, 1);
    divide = 0;

    // breakpoint at 0x10, PC advances 4 per pulse
    pcAddr = 0; breakEn = 1; runReq = 1; n = 0;
`ifdef SM_STEP_BREAKPOINT_EN
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (cpuClkEn) begin n++; pcAddr = pcAddr + 4; end
    end
    chk("bp_pulses", n, 4);
    chk("bp_pc", pcAddr, 32'h10);
    chk("bp_hit", bpHit, 1);
    chk("bp_halted", halted, 1);
    runReq = 0;
    @(negedge clk);
    runReq = 1; n = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (cpuClkEn) begin n++; pcAddr = pcAddr + 4; end
    end
    chk("bp_resume_pulses", n, 2);
    chk("bp_resume_pc", pcAddr, 32'h18);
    chk("bp_resume_hit", bpHit, 0);
`else
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (cpuClkEn) begin n++; pcAddr = pcAddr + 4; end
    end
    chk("nobp_pulses", n, 7);
    chk("nobp_pc", pcAddr, 32'h1c);
    chk("nobp_hit", bpHit, 0);
`endif
    runReq = 0; breakEn = 0; pcAddr = 0;
    repeat (2) @(negedge clk);

    // reset in the middle of a 200-cycle burst
    burstLen = 200; burstReq = 1; n = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (cpuClkEn) n++;
      if (k == 1) burstReq = 0;
      if (n == 50) break;
    end
    chk("rst_burst_reach", n, 50);
    rst = 1;
    @(negedge clk);
    chk("rst_burst_en", cpuClkEn, 0);
    chk("rst_burst_cnt", cycleCnt, 0);
    chk("rst_burst_state", {state, halted}, {2'd0, 1'b1});
    rst = 0;
    repeat (3) @(negedge clk);

    // randomized traffic, checked cycle by cycle by the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = $urandom_range(0, 199) == 0;
      if ($urandom_range(0, 19) == 0) runReq = !runReq;
      stepReq = $urandom_range(0, 3) == 0;
      burstReq = $urandom_range(0, 3) == 0;
      burstLen = 8'($urandom_range(0, 5));
      divide = 4'($urandom_range(0, 2));
      breakEn = $urandom_range(0, 1) == 1;
      pcAddr = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      breakAddr = 32'h8;
    end
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
